// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encoding and special scan codes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: head is visible the cycle after the write, zero-latency pop.
// Push while full is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop && !empty;
  assign wr_en   = push && (!full || rd_en);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap on natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 receiver with glitch filter, frame checks and timeout feeding a FWFT scan-code FIFO.
// Byte appears at rd_data the cycle after its stop bit; bytes arriving while full are dropped (overflow). Optional: PS2_BREAK_FILTER_EN.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                          clk100Mhz,
  input  logic                          reset,
  input  logic                          PS2Clk,
  input  logic                          PS2Data,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          strobe,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_s, data_s;
  logic                   fclk;
  logic [FW-1:0]          filt_cnt;
  logic                   filt_done, fall;
  logic [TW-1:0]          idle_cnt;
  logic                   timeout;

  rx_state_t  state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shreg, shreg_n;
  logic       par_bit, par_bit_n;
  logic       good, set_perr, set_ferr;
  logic       push, push_ok, pop, full, empty;

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], PS2Clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], PS2Data};
    end
  end

  // The sample event fires in the same cycle the filter commits fclk 1->0.
  assign filt_done = (clk_s != fclk) && (filt_cnt == FW'(FILTER_CYCLES - 1));
  assign fall      = filt_done && fclk;

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      fclk     <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == fclk) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      fclk     <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk100Mhz) begin
    if (reset || state == IDLE || fall || timeout) idle_cnt <= '0;
    else                                           idle_cnt <= idle_cnt + 1'b1;
  end

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_bit <= par_bit_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_bit_n = par_bit;
    good      = 1'b0;
    set_perr  = 1'b0;
    set_ferr  = 1'b0;
    if (timeout) begin
      state_n  = IDLE;
      set_ferr = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!data_s) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shreg_n   = {data_s, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_bit_n = data_s;
          state_n   = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!data_s)                  set_ferr = 1'b1;
          else if (!(^{shreg, par_bit})) set_perr = 1'b1;
          else                          good     = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_pending;

  // A break code swallows itself and the key code that follows it.
  assign push = good && !break_pending && (shreg != BREAK_CODE);

  always_ff @(posedge clk100Mhz) begin
    if (reset)     break_pending <= 1'b0;
    else if (good) break_pending <= !break_pending && (shreg == BREAK_CODE);
  end
`else
  assign push = good;
`endif

  assign rd_valid = !empty;
  assign pop      = rd_valid && rd_ready;
  assign push_ok  = push && (!full || pop);

  always_ff @(posedge clk100Mhz) begin
    if (reset) begin
      strobe     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      strobe <= push_ok;
      if (set_perr)            parity_err <= 1'b1;
      if (set_ferr)            frame_err  <= 1'b1;
      if (push && full && !pop) overflow  <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk100Mhz),
    .reset   (reset),
    .push    (push),
    .wr_data (shreg),
    .pop     (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo; PS/2 clock is shortened (40 core cycles per bit) to keep runs short.
module tb_ps2_rx_fifo;
  import ps2_pkg::*;

  logic       clk100Mhz = 1'b0;
  logic       reset     = 1'b1;
  logic       PS2Clk    = 1'b1;
  logic       PS2Data   = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready  = 1'b0;
  logic [3:0] count;
  logic       strobe;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int total  = 0;
  int passes = 0;
  int strobe_cnt = 0;
  int strobe_base;

  always #5 clk100Mhz = ~clk100Mhz;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (8),
    .SYNC_STAGES    (2),
    .FILTER_CYCLES  (8),
    .TIMEOUT_CYCLES (300)
  ) dut (
    .clk100Mhz  (clk100Mhz),
    .reset      (reset),
    .PS2Clk     (PS2Clk),
    .PS2Data    (PS2Data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .strobe     (strobe),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always @(posedge clk100Mhz) if (strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk100Mhz);
  endtask

  task automatic send_bit(input logic b);
    PS2Data = b;
    cycles(10);
    PS2Clk = 1'b0;
    cycles(20);
    PS2Clk = 1'b1;
    cycles(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(1'b1);
    PS2Data = 1'b1;
    cycles(40);
  endtask

  task automatic pop_one;
    rd_ready = 1'b1;
    cycles(1);
    rd_ready = 1'b0;
  endtask

  initial begin
    cycles(5);
    reset = 1'b0;
    cycles(2);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_strobe", 32'(strobe), 32'd0);
    check("reset_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    check("reset_state", 32'(dut.state), 32'(IDLE));

    // Single good frame.
    strobe_base = strobe_cnt;
    send_frame(8'h1C, 1'b0);
    check("t1_rd_data", 32'(rd_data), 32'h1C);
    check("t1_rd_valid", 32'(rd_valid), 32'd1);
    check("t1_count", 32'(count), 32'd1);
    check("t1_strobes", 32'(strobe_cnt - strobe_base), 32'd1);
    check("t1_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    pop_one();
    check("t1_count_after_pop", 32'(count), 32'd0);
    check("t1_valid_after_pop", 32'(rd_valid), 32'd0);

    // Break sequence.
    strobe_base = strobe_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
`ifdef PS2_BREAK_FILTER_EN
    check("t2_count", 32'(count), 32'd0);
    check("t2_strobes", 32'(strobe_cnt - strobe_base), 32'd0);
`else
    check("t2_count", 32'(count), 32'd2);
    check("t2_strobes", 32'(strobe_cnt - strobe_base), 32'd2);
    check("t2_first", 32'(rd_data), 32'hF0);
    pop_one();
    check("t2_second", 32'(rd_data), 32'h1C);
    pop_one();
    check("t2_drained", 32'(count), 32'd0);
`endif

    // Bad parity, then recovery.
    strobe_base = strobe_cnt;
    send_frame(8'h1C, 1'b1);
    check("t3_count", 32'(count), 32'd0);
    check("t3_parity_err", 32'(parity_err), 32'd1);
    check("t3_frame_err", 32'(frame_err), 32'd0);
    check("t3_strobes", 32'(strobe_cnt - strobe_base), 32'd0);
    send_frame(8'h29, 1'b0);
    check("t3_next_data", 32'(rd_data), 32'h29);
    check("t3_next_count", 32'(count), 32'd1);
    pop_one();

    // Overflow with consumer stalled.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
    check("t4_count_full", 32'(count), 32'd8);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_head", 32'(rd_data), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("t4_drain_%0d", i), 32'(rd_data), 32'(i));
      pop_one();
    end
    check("t4_empty", 32'(count), 32'd0);
    check("t4_valid_empty", 32'(rd_valid), 32'd0);

    // Truncated frame, recovered by timeout.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    PS2Data = 1'b1;
    check("t5_mid_state", 32'(dut.state), 32'(DATA));
    check("t5_no_ferr_yet", 32'(frame_err), 32'd0);
    cycles(1000);
    check("t5_frame_err", 32'(frame_err), 32'd1);
    check("t5_state_idle", 32'(dut.state), 32'(IDLE));
    check("t5_count", 32'(count), 32'd0);
    send_frame(8'h29, 1'b0);
    check("t5_next_data", 32'(rd_data), 32'h29);
    check("t5_next_count", 32'(count), 32'd1);

    // Reset clears flags and FIFO; then a short clock glitch with data low.
    reset = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
    check("r2_flags", 32'({parity_err, frame_err, overflow}), 32'd0);
    check("r2_count", 32'(count), 32'd0);
    strobe_base = strobe_cnt;
    PS2Data = 1'b0;
    cycles(5);
    PS2Clk = 1'b0;
    cycles(3);
    PS2Clk = 1'b1;
    cycles(40);
    PS2Data = 1'b1;
    check("t6_state", 32'(dut.state), 32'(IDLE));
    check("t6_count", 32'(count), 32'd0);
    check("t6_strobes", 32'(strobe_cnt - strobe_base), 32'd0);
    check("t6_flags", 32'({parity_err, frame_err, overflow}), 32'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
